// File: rtl/hazard_ctrl_unit.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_ctrl_unit
//  Purpose  : Pipeline hazard controller for the 5-stage core. Sits beside the
//             ID stage and drives the PC / IF/ID / ID/EX write enables, bubble
//             insertion (ctrlMux) and IF/ID flush. It handles:
//               - load-use hazards with a configurable number of bubbles,
//               - multi-cycle EX operations (multiply) by freezing the front
//                 of the pipeline,
//               - taken branches resolved in EX by flushing IF/ID.
//             A saturating counter records the number of cycles in which the
//             PC was held.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk             in   1       core clock, rising edge
//    rst_n           in   1       asynchronous active-low reset
//    IF_ID_op1       in   REG_AW  source register 1 of the ID instruction
//    IF_ID_op2       in   REG_AW  source register 2 of the ID instruction
//    IF_ID_op1_used  in   1       op1 is actually read
//    IF_ID_op2_used  in   1       op2 is actually read
//    ID_EX_op2       in   REG_AW  destination register of the EX instruction
//    ID_EX_memRead   in   1       EX instruction is a load
//    ID_EX_mulStart  in   1       first EX cycle of a multi-cycle op (pulse)
//    EX_branchTaken  in   1       branch resolved taken in EX
//    PCwrite         out  1       PC update enable
//    IF_ID_write     out  1       IF/ID register enable
//    ID_EX_write     out  1       ID/EX register enable
//    ctrlMux         out  1       1 = bubble (zero controls into ID/EX)
//    IF_ID_flush     out  1       1 = clear IF/ID to NOP
//    hz_state        out  2       0 IDLE, 1 LD_STALL, 2 MUL_BUSY
//    stall_cnt       out  CNT_W   cycles with PCwrite=0, saturating
// ============================================================================
module hazard_ctrl_unit #(
    parameter int REG_AW     = 4,   // register address width
    parameter int LOAD_STALL = 1,   // bubbles per load-use hazard (1..8)
    parameter int MUL_LAT    = 4,   // multi-cycle EX latency (2..16)
    parameter int R0_ZERO    = 1,   // 1 = register 0 never hazards
    parameter int CNT_W      = 16   // stall performance counter width
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] IF_ID_op1,
    input  logic [REG_AW-1:0] IF_ID_op2,
    input  logic              IF_ID_op1_used,
    input  logic              IF_ID_op2_used,
    input  logic [REG_AW-1:0] ID_EX_op2,
    input  logic              ID_EX_memRead,
    input  logic              ID_EX_mulStart,
    input  logic              EX_branchTaken,
    output logic              PCwrite,
    output logic              IF_ID_write,
    output logic              ID_EX_write,
    output logic              ctrlMux,
    output logic              IF_ID_flush,
    output logic [1:0]        hz_state,
    output logic [CNT_W-1:0]  stall_cnt
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_LD_STALL = 2'd1;
    localparam logic [1:0] S_MUL_BUSY = 2'd2;

    // Down-counter holds "extra cycles remaining after this one". The first
    // stall/freeze cycle is issued from IDLE and the last one is the cycle
    // where the counter reads zero, hence the -2 / -3 offsets. Four bits cover
    // the largest preload (MUL_LAT-3 = 13).
    localparam logic [3:0] C_LD_INIT  = (LOAD_STALL >= 2) ? 4'(LOAD_STALL - 2) : 4'd0;
    localparam logic [3:0] C_MUL_INIT = (MUL_LAT >= 3)    ? 4'(MUL_LAT - 3)    : 4'd0;

    // Output sets packed as {PCwrite, IF_ID_write, ID_EX_write, ctrlMux, IF_ID_flush}
    localparam logic [4:0] C_NORMAL = 5'b11100;
    localparam logic [4:0] C_STALL  = 5'b00110;
    localparam logic [4:0] C_FREEZE = 5'b00000;
    localparam logic [4:0] C_FLUSH  = 5'b11111;

    logic [1:0]       r_state;
    logic [3:0]       r_cnt;
    logic [CNT_W-1:0] r_stall_cnt;

    logic [1:0] w_next_state;
    logic [3:0] w_next_cnt;
    logic [4:0] w_ctl;
    logic [4:0] w_out;
    logic       w_dst_zero;
    logic       w_match1;
    logic       w_match2;
    logic       w_lu;

    // ------------------------------------------------------------------------
    // Load-use detection. An operand that is not read can never match, and a
    // load to the hard-wired zero register is harmless when R0_ZERO is set.
    // ------------------------------------------------------------------------
    assign w_dst_zero = (R0_ZERO != 0) && (ID_EX_op2 == '0);
    assign w_match1   = IF_ID_op1_used && (IF_ID_op1 == ID_EX_op2);
    assign w_match2   = IF_ID_op2_used && (IF_ID_op2 == ID_EX_op2);
    assign w_lu       = ID_EX_memRead && !w_dst_zero && (w_match1 || w_match2);

    // ------------------------------------------------------------------------
    // Next-state and output decode. In IDLE the priority is
    // branch > multi-cycle op > load-use: a load-use seen together with a
    // taken branch belongs to the wrong path and is dropped.
    // ------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_ctl        = C_NORMAL;
        case (r_state)
            S_IDLE: begin
                if (EX_branchTaken) begin
                    w_ctl = C_FLUSH;
                end else if (ID_EX_mulStart) begin
                    w_ctl = C_FREEZE;
                    if (MUL_LAT > 2) begin
                        w_next_state = S_MUL_BUSY;
                        w_next_cnt   = C_MUL_INIT;
                    end
                end else if (w_lu) begin
                    w_ctl = C_STALL;
                    if (LOAD_STALL > 1) begin
                        w_next_state = S_LD_STALL;
                        w_next_cnt   = C_LD_INIT;
                    end
                end
            end
            S_LD_STALL: begin
                w_ctl = C_STALL;
                if (r_cnt == 4'd0) begin
                    w_next_state = S_IDLE;
                end else begin
                    w_next_cnt = r_cnt - 4'd1;
                end
            end
            S_MUL_BUSY: begin
                w_ctl = C_FREEZE;
                if (r_cnt == 4'd0) begin
                    w_next_state = S_IDLE;
                end else begin
                    w_next_cnt = r_cnt - 4'd1;
                end
            end
            default: begin
                w_next_state = S_IDLE;
                w_next_cnt   = 4'd0;
            end
        endcase
    end

    // While reset is asserted the pipeline must run freely, independent of
    // whatever the other inputs are doing.
    assign w_out = rst_n ? w_ctl : C_NORMAL;

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

    // Saturating count of cycles in which the PC was held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (!w_out[4] && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign PCwrite     = w_out[4];
    assign IF_ID_write = w_out[3];
    assign ID_EX_write = w_out[2];
    assign ctrlMux     = w_out[1];
    assign IF_ID_flush = w_out[0];
    assign hz_state    = r_state;
    assign stall_cnt   = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hazard_ctrl_unit
//  Purpose  : Self-checking bench for hazard_ctrl_unit. Three instances share
//             the same stimulus: (0) LOAD_STALL=1, (1) LOAD_STALL=3,
//             (2) LOAD_STALL=3 with a 2-bit stall counter. All use MUL_LAT=4.
//             Outputs are compared against a reference model that tracks the
//             number of held cycles still owed to each hazard.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl_unit;

    localparam int N       = 3;
    localparam int MUL_LAT = 4;

    localparam logic [4:0] C_NORMAL = 5'b11100;
    localparam logic [4:0] C_STALL  = 5'b00110;
    localparam logic [4:0] C_FREEZE = 5'b00000;
    localparam logic [4:0] C_FLUSH  = 5'b11111;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] op1, op2, exdst;
    logic       u1, u2, mr, ms, br;

    logic [4:0]  obs_o [N];
    logic [1:0]  obs_s [N];
    logic [15:0] obs_c [N];

    int checks   = 0;
    int failures = 0;

    // reference model state: 0 free, 1 owes load bubbles, 2 owes mul freezes
    int          m_mode [N];
    int          m_left [N];
    int          m_cnt  [N];
    logic [4:0]  exp_o  [N];
    logic [1:0]  exp_s  [N];
    logic [15:0] exp_c  [N];

    always #5 clk = ~clk;

    for (genvar k = 0; k < N; k++) begin : g_dut
        localparam int LS = (k == 0) ? 1 : 3;
        localparam int CW = (k == 2) ? 2 : 16;
        logic          pcw, ifw, exw, cm, fl;
        logic [1:0]    st;
        logic [CW-1:0] sc;
        hazard_ctrl_unit #(
            .REG_AW(4), .LOAD_STALL(LS), .MUL_LAT(MUL_LAT), .R0_ZERO(1), .CNT_W(CW)
        ) u_dut (
            .clk(clk), .rst_n(rst_n),
            .IF_ID_op1(op1), .IF_ID_op2(op2),
            .IF_ID_op1_used(u1), .IF_ID_op2_used(u2),
            .ID_EX_op2(exdst), .ID_EX_memRead(mr),
            .ID_EX_mulStart(ms), .EX_branchTaken(br),
            .PCwrite(pcw), .IF_ID_write(ifw), .ID_EX_write(exw),
            .ctrlMux(cm), .IF_ID_flush(fl),
            .hz_state(st), .stall_cnt(sc)
        );
        assign obs_o[k] = {pcw, ifw, exw, cm, fl};
        assign obs_s[k] = st;
        assign obs_c[k] = 16'(sc);
    end

    function automatic int p_ls(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic int p_max(input int k);
        return (k == 2) ? 3 : 65535;
    endfunction

    function automatic bit ref_lu();
        return mr && (exdst != 4'd0) && ((u1 && op1 == exdst) || (u2 && op2 == exdst));
    endfunction

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            m_mode[k] = 0;
            m_left[k] = 0;
            m_cnt[k]  = 0;
        end
    endtask

    // Expected outputs for the current cycle from current inputs.
    task automatic model_eval();
        for (int k = 0; k < N; k++) begin
            exp_s[k] = 2'(m_mode[k]);
            exp_c[k] = 16'(m_cnt[k]);
            if (m_mode[k] == 1)      exp_o[k] = C_STALL;
            else if (m_mode[k] == 2) exp_o[k] = C_FREEZE;
            else if (br)             exp_o[k] = C_FLUSH;
            else if (ms)             exp_o[k] = C_FREEZE;
            else if (ref_lu())       exp_o[k] = C_STALL;
            else                     exp_o[k] = C_NORMAL;
        end
    endtask

    // Advance the model across one rising edge (uses this cycle's exp_o).
    task automatic model_clock();
        for (int k = 0; k < N; k++) begin
            if (!exp_o[k][4] && m_cnt[k] < p_max(k)) m_cnt[k]++;
            if (m_mode[k] == 0) begin
                if (!br && ms) begin
                    if (MUL_LAT - 2 > 0) begin
                        m_mode[k] = 2;
                        m_left[k] = MUL_LAT - 2;
                    end
                end else if (!br && ref_lu() && p_ls(k) > 1) begin
                    m_mode[k] = 1;
                    m_left[k] = p_ls(k) - 1;
                end
            end else begin
                m_left[k]--;
                if (m_left[k] == 0) m_mode[k] = 0;
            end
        end
    endtask

    task automatic set_in(input logic [3:0] a1, input logic [3:0] a2, input logic e1,
                          input logic e2, input logic [3:0] d, input logic r,
                          input logic m, input logic b);
        op1 = a1; op2 = a2; u1 = e1; u2 = e2; exdst = d; mr = r; ms = m; br = b;
    endtask

    // Leaves the bench at a falling edge with reset released.
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        set_in(4'd1, 4'd1, 1, 1, 4'd1, 1, 1, 1);
        model_reset();
        for (int c = 0; c < 2; c++) begin
            #1;
            for (int k = 0; k < N; k++) begin
                checks++;
                if ({obs_o[k], obs_s[k], obs_c[k]} !== {C_NORMAL, 2'd0, 16'd0}) begin
                    failures++;
                    $display("FAIL reset dut%0d t=%0t: out=%b st=%0d cnt=%0d expected out=%b st=0 cnt=0",
                             k, $time, obs_o[k], obs_s[k], obs_c[k], C_NORMAL);
                end
            end
            @(negedge clk);
        end
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
    endtask

    // sc 0: real hazard, 1: destination is r0, 2: matching operand unused
    task automatic test_load_use();
        for (int sc = 0; sc < 3; sc++) begin
            do_reset();
            for (int cyc = 0; cyc < 6; cyc++) begin
                if (cyc == 0) set_in(4'd1, 4'd5, (sc != 2), 1, (sc == 1) ? 4'd0 : 4'd1, 1, 0, 0);
                else          set_in(0, 0, 0, 0, 0, 0, 0, 0);
                if (sc == 1 && cyc == 0) op1 = 4'd0;
                #1;
                model_eval();
                for (int k = 0; k < N; k++) begin
                    checks++;
                    if ({obs_o[k], obs_s[k], obs_c[k]} !== {exp_o[k], exp_s[k], exp_c[k]}) begin
                        failures++;
                        $display("FAIL load_use sc%0d dut%0d cyc%0d: out=%b st=%0d cnt=%0d expected out=%b st=%0d cnt=%0d",
                                 sc, k, cyc, obs_o[k], obs_s[k], obs_c[k], exp_o[k], exp_s[k], exp_c[k]);
                    end
                end
                @(posedge clk);
                model_clock();
                @(negedge clk);
            end
            #1;
            checks++;
            if (obs_c[0] !== ((sc == 0) ? 16'd1 : 16'd0) || obs_c[1] !== ((sc == 0) ? 16'd3 : 16'd0)) begin
                failures++;
                $display("FAIL load_use_total sc%0d: cnt0=%0d cnt1=%0d expected %0d and %0d",
                         sc, obs_c[0], obs_c[1], (sc == 0) ? 1 : 0, (sc == 0) ? 3 : 0);
            end
        end
    endtask

    task automatic test_mul();
        do_reset();
        for (int cyc = 0; cyc < 6; cyc++) begin
            if (cyc == 0)      set_in(0, 0, 0, 0, 0, 0, 1, 0);
            else if (cyc == 1) set_in(4'd3, 4'd0, 1, 0, 4'd3, 1, 0, 1);
            else               set_in(0, 0, 0, 0, 0, 0, 0, 0);
            #1;
            model_eval();
            for (int k = 0; k < N; k++) begin
                checks++;
                if ({obs_o[k], obs_s[k], obs_c[k]} !== {exp_o[k], exp_s[k], exp_c[k]}) begin
                    failures++;
                    $display("FAIL mul dut%0d cyc%0d: out=%b st=%0d cnt=%0d expected out=%b st=%0d cnt=%0d",
                             k, cyc, obs_o[k], obs_s[k], obs_c[k], exp_o[k], exp_s[k], exp_c[k]);
                end
            end
            @(posedge clk);
            model_clock();
            @(negedge clk);
        end
        #1;
        checks++;
        if (obs_c[0] !== 16'd3) begin
            failures++;
            $display("FAIL mul_total: cnt=%0d expected 3", obs_c[0]);
        end
    endtask

    task automatic test_branch_lu();
        do_reset();
        for (int cyc = 0; cyc < 4; cyc++) begin
            if (cyc == 0) set_in(4'd2, 4'd2, 1, 1, 4'd2, 1, 0, 1);
            else          set_in(0, 0, 0, 0, 0, 0, 0, 0);
            #1;
            model_eval();
            for (int k = 0; k < N; k++) begin
                checks++;
                if ({obs_o[k], obs_s[k], obs_c[k]} !== {exp_o[k], exp_s[k], exp_c[k]}) begin
                    failures++;
                    $display("FAIL branch_lu dut%0d cyc%0d: out=%b st=%0d cnt=%0d expected out=%b st=%0d cnt=%0d",
                             k, cyc, obs_o[k], obs_s[k], obs_c[k], exp_o[k], exp_s[k], exp_c[k]);
                end
            end
            if (cyc == 0) begin
                checks++;
                if (obs_o[1] !== C_FLUSH) begin
                    failures++;
                    $display("FAIL branch_flush: out=%b expected %b", obs_o[1], C_FLUSH);
                end
            end
            @(posedge clk);
            model_clock();
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int cyc = 0; cyc < 2; cyc++) begin
            if (cyc == 0) set_in(4'd7, 4'd0, 1, 0, 4'd7, 1, 0, 0);
            else          set_in(0, 0, 0, 0, 0, 0, 0, 0);
            #1;
            model_eval();
            for (int k = 0; k < N; k++) begin
                checks++;
                if ({obs_o[k], obs_s[k], obs_c[k]} !== {exp_o[k], exp_s[k], exp_c[k]}) begin
                    failures++;
                    $display("FAIL reset_mid_pre dut%0d cyc%0d: out=%b st=%0d cnt=%0d expected out=%b st=%0d cnt=%0d",
                             k, cyc, obs_o[k], obs_s[k], obs_c[k], exp_o[k], exp_s[k], exp_c[k]);
                end
            end
            if (cyc == 0) begin
                @(posedge clk);
                model_clock();
                @(negedge clk);
            end
        end
        // second stall cycle of instance 1: pull reset right now
        rst_n = 1'b0;
        model_reset();
        #1;
        for (int k = 0; k < N; k++) begin
            checks++;
            if ({obs_o[k], obs_s[k], obs_c[k]} !== {C_NORMAL, 2'd0, 16'd0}) begin
                failures++;
                $display("FAIL reset_mid dut%0d: out=%b st=%0d cnt=%0d expected out=%b st=0 cnt=0",
                         k, obs_o[k], obs_s[k], obs_c[k], C_NORMAL);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int cyc = 0; cyc < 2; cyc++) begin
            #1;
            model_eval();
            for (int k = 0; k < N; k++) begin
                checks++;
                if ({obs_o[k], obs_s[k], obs_c[k]} !== {exp_o[k], exp_s[k], exp_c[k]}) begin
                    failures++;
                    $display("FAIL reset_mid_post dut%0d cyc%0d: out=%b st=%0d cnt=%0d expected out=%b st=%0d cnt=%0d",
                             k, cyc, obs_o[k], obs_s[k], obs_c[k], exp_o[k], exp_s[k], exp_c[k]);
                end
            end
            @(posedge clk);
            model_clock();
            @(negedge clk);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        for (int cyc = 0; cyc < 7; cyc++) begin
            set_in(4'd4, 4'd0, 1, 0, 4'd4, 1, 0, 0);
            #1;
            model_eval();
            for (int k = 0; k < N; k++) begin
                checks++;
                if ({obs_o[k], obs_s[k], obs_c[k]} !== {exp_o[k], exp_s[k], exp_c[k]}) begin
                    failures++;
                    $display("FAIL saturate dut%0d cyc%0d: out=%b st=%0d cnt=%0d expected out=%b st=%0d cnt=%0d",
                             k, cyc, obs_o[k], obs_s[k], obs_c[k], exp_o[k], exp_s[k], exp_c[k]);
                end
            end
            @(posedge clk);
            model_clock();
            @(negedge clk);
        end
        #1;
        checks++;
        if (obs_c[2] !== 16'd3) begin
            failures++;
            $display("FAIL saturate_total: cnt=%0d expected 3", obs_c[2]);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            set_in(4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   4'($urandom_range(0, 3)), ($urandom_range(0, 1) == 1),
                   ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0));
            #1;
            model_eval();
            for (int k = 0; k < N; k++) begin
                checks++;
                if ({obs_o[k], obs_s[k], obs_c[k]} !== {exp_o[k], exp_s[k], exp_c[k]}) begin
                    failures++;
                    $display("FAIL random dut%0d cyc%0d: out=%b st=%0d cnt=%0d expected out=%b st=%0d cnt=%0d",
                             k, cyc, obs_o[k], obs_s[k], obs_c[k], exp_o[k], exp_s[k], exp_c[k]);
                end
            end
            @(posedge clk);
            model_clock();
            @(negedge clk);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        test_reset();
        test_load_use();
        test_mul();
        test_branch_lu();
        test_reset_mid();
        test_saturate();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hazard_ctrl_unit.md
Name: hazard_ctrl_unit

Overview:
- Parametrised pipeline hazard controller for the 5-stage core. Sits beside the ID stage and drives PC, IF/ID and ID/EX write enables, bubble insertion and flush.
- Generalises the single-cycle load-use detector in three ways:
  - configurable register-address width;
  - multi-cycle load-use stall;
  - multi-cycle EX-unit (multiply) freeze and taken-branch flush.
- Sequenced by a small FSM with down-counter, plus a saturating stall-cycle performance counter.

Parameters:
- REG_AW, 4: register address width.
- LOAD_STALL, 1: bubbles inserted per load-use hazard (1..8).
- MUL_LAT, 4: EX latency of multi-cycle unit in cycles (2..16).
- R0_ZERO, 1: 1 = register address 0 never causes a hazard.
- CNT_W, 16: width of stall performance counter.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- IF_ID_op1  in  REG_AW  source reg 1 of instruction in ID.
- IF_ID_op2  in  REG_AW  source reg 2 of instruction in ID.
- IF_ID_op1_used  in  1  op1 actually read.
- IF_ID_op2_used  in  1  op2 actually read.
- ID_EX_op2  in  REG_AW  destination reg of instruction in EX.
- ID_EX_memRead  in  1  EX instruction is a load.
- ID_EX_mulStart  in  1  first EX cycle of a multi-cycle op (1-cycle pulse).
- EX_branchTaken  in  1  branch resolved taken in EX.
- PCwrite  out  1  PC update enable.
- IF_ID_write  out  1  IF/ID register enable.
- ID_EX_write  out  1  ID/EX register enable.
- ctrlMux  out  1  1 = zero control signals into ID/EX (bubble).
- IF_ID_flush  out  1  1 = clear IF/ID to NOP.
- hz_state  out  2  FSM state: 0 IDLE, 1 LD_STALL, 2 MUL_BUSY.
- stall_cnt  out  CNT_W  total cycles with PCwrite=0, saturating.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, internal counter=0, stall_cnt=0.
  - While rst_n is low, outputs are forced to PCwrite=1, IF_ID_write=1, ID_EX_write=1, ctrlMux=0, IF_ID_flush=0, regardless of inputs.
  - Reset mid-stall aborts the stall immediately.
- Load-use detect (combinational):
  - lu = ID_EX_memRead && !(R0_ZERO && ID_EX_op2==0) && ((IF_ID_op1_used && IF_ID_op1==ID_EX_op2) || (IF_ID_op2_used && IF_ID_op2==ID_EX_op2)).
  - Unused operands never match.
- Output sets (combinational from state + inputs):
  - NORMAL: PCwrite=1, IF_ID_write=1, ID_EX_write=1, ctrlMux=0, IF_ID_flush=0.
  - STALL: PCwrite=0, IF_ID_write=0, ID_EX_write=1, ctrlMux=1, IF_ID_flush=0.
  - FREEZE: PCwrite=0, IF_ID_write=0, ID_EX_write=0, ctrlMux=0, IF_ID_flush=0.
  - FLUSH: PCwrite=1, IF_ID_write=1, ID_EX_write=1, ctrlMux=1, IF_ID_flush=1.
- IDLE, priority branch > mul > load-use:
  - EX_branchTaken: FLUSH this cycle; stay IDLE; any simultaneous lu is discarded as wrong-path.
  - else ID_EX_mulStart: FREEZE this cycle.
    - MUL_LAT==2: stay IDLE.
    - else: go MUL_BUSY with cnt=MUL_LAT-3.
  - else lu: STALL this cycle.
    - LOAD_STALL==1: stay IDLE.
    - else: go LD_STALL with cnt=LOAD_STALL-2.
  - else NORMAL.
- LD_STALL:
  - STALL every cycle; all other inputs ignored.
  - cnt==0: go IDLE; else cnt-1.
  - Total bubbles = LOAD_STALL.
- MUL_BUSY:
  - FREEZE every cycle; branch, lu and mulStart ignored.
  - cnt==0: go IDLE; else cnt-1.
  - Total freeze cycles = MUL_LAT-1, so the multi-cycle op occupies EX for MUL_LAT cycles.
- stall_cnt:
  - Increments on each rising edge where PCwrite==0 and rst_n==1.
  - Holds at 2^CNT_W-1; no wrap.
- No combinational path from any output back to an input.
- ID_EX_mulStart and ID_EX_memRead high together is illegal decode; mul wins.

Test Plan:
- Reset, defaults, all inputs 0 → PCwrite=1, IF_ID_write=1, ID_EX_write=1, ctrlMux=0, IF_ID_flush=0, hz_state=0, stall_cnt=0.
- LOAD_STALL=1; op1=0001 used, ID_EX_op2=0001, memRead=1 for one cycle → exactly one STALL cycle, then NORMAL; stall_cnt=1.
- Repeat with ID_EX_op2=0000 (R0_ZERO=1), and separately with op1_used=0 → no stall.
- LOAD_STALL=3, same hazard → 3 consecutive STALL cycles (hz_state 0,1,1), NORMAL on the 4th; stall_cnt=3.
- MUL_LAT=4, mulStart pulse at cycle T → FREEZE at T, T+1, T+2, NORMAL at T+3.
  - lu and branch asserted at T+1 are ignored.
  - stall_cnt=3.
- EX_branchTaken and lu in the same cycle → FLUSH (ctrlMux=1, IF_ID_flush=1, PCwrite=1) with no STALL.
- Reset mid-operation: LOAD_STALL=3, assert rst_n=0 during 2nd stall cycle → outputs NORMAL immediately, hz_state=0, stall_cnt=0.
- CNT_W=2, 5 stall cycles → stall_cnt saturates at 3.
